// File: rtl/fetch_pc_gen.sv
// Instruction-fetch front end: owns the fetch PC, issues one I-cache request at a time
// and forwards the registered fetch word with its PC to the compressed realigner.
module fetch_pc_gen #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic            fence_i_i,
  input  logic            stall_pc_i,
  input  logic            if_stall_i,
  input  logic            i_cache_valid_i,
  input  logic [31:0]     i_cache_inst_i,
  input  logic            i_cache_flush_done_i,
  output logic            i_cache_request_o,
  output logic            i_cache_req_kill_o,
  output logic            i_cache_flush_o,
  output logic [XLEN-1:0] i_cache_addr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [31:0]     inst_o,
  output logic            inst_valid_o,
  output logic            sel_for_branch_o,
  output logic [1:0]      dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic            hold;
  logic            capture;
  logic [XLEN-1:0] pc_step;
  logic [XLEN-1:0] redirect_pc;

  // Cache handshake: i_cache_request_o stays high from the cycle after issue until the
  // cycle i_cache_valid_i returns; a kill in WAIT withdraws it and no response follows.
  assign hold        = stall_pc_i | if_stall_i;
  assign capture     = (state_q == S_WAIT) && i_cache_valid_i && !branch_taken_i;
  assign pc_step     = (i_cache_inst_i[1:0] == 2'b11) ? XLEN'(4) : XLEN'(2);
  assign redirect_pc = {branch_target_i[XLEN-1:1], 1'b0};

  assign i_cache_addr_o = pc_q;
  assign dbg_state_o    = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (branch_taken_i) begin
          state_d = fence_i_i ? S_FLUSH : S_IDLE;
        end else if (!hold) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (branch_taken_i) begin
          state_d = fence_i_i ? S_FLUSH : S_IDLE;
        end else if (i_cache_valid_i) begin
          state_d = hold ? S_IDLE : S_WAIT;
        end
      end
      S_FLUSH: begin
        // A redirect here only retargets the PC; the flush must still complete.
        if (i_cache_flush_done_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    i_cache_request_o  = 1'b0;
    i_cache_req_kill_o = 1'b0;
    i_cache_flush_o    = 1'b0;
    case (state_q)
      S_WAIT: begin
        i_cache_request_o  = !branch_taken_i;
        i_cache_req_kill_o = branch_taken_i;
      end
      S_FLUSH: i_cache_flush_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q             <= RESET_PC;
      pc_o             <= RESET_PC;
      inst_o           <= 32'h0000_0013;
      inst_valid_o     <= 1'b0;
      sel_for_branch_o <= 1'b0;
    end else begin
      sel_for_branch_o <= branch_taken_i;
      if (branch_taken_i) begin
        pc_q         <= redirect_pc;
        inst_valid_o <= 1'b0;
      end else if (capture) begin
        inst_o       <= i_cache_inst_i;
        pc_o         <= pc_q;
        inst_valid_o <= 1'b1;
        pc_q         <= pc_q + pc_step;
      end else if (!hold) begin
        // Consumed word is not replayed to the realigner.
        inst_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen: reset, sequential fetch, hold, redirect/kill,
// fence.i flush, PC wrap and mid-operation reset.
module tb_fetch_pc_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic        fence_i_i;
  logic        stall_pc_i;
  logic        if_stall_i;
  logic        i_cache_valid_i;
  logic [31:0] i_cache_inst_i;
  logic        i_cache_flush_done_i;
  logic        i_cache_request_o;
  logic        i_cache_req_kill_o;
  logic        i_cache_flush_o;
  logic [31:0] i_cache_addr_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        sel_for_branch_o;
  logic [1:0]  dbg_state_o;

  int tests = 0;
  int fails = 0;

  fetch_pc_gen #(.XLEN(32), .RESET_PC(32'h0000_0100)) dut (
    .clk                  (clk),
    .reset                (reset),
    .branch_taken_i       (branch_taken_i),
    .branch_target_i      (branch_target_i),
    .fence_i_i            (fence_i_i),
    .stall_pc_i           (stall_pc_i),
    .if_stall_i           (if_stall_i),
    .i_cache_valid_i      (i_cache_valid_i),
    .i_cache_inst_i       (i_cache_inst_i),
    .i_cache_flush_done_i (i_cache_flush_done_i),
    .i_cache_request_o    (i_cache_request_o),
    .i_cache_req_kill_o   (i_cache_req_kill_o),
    .i_cache_flush_o      (i_cache_flush_o),
    .i_cache_addr_o       (i_cache_addr_o),
    .pc_o                 (pc_o),
    .inst_o               (inst_o),
    .inst_valid_o         (inst_valid_o),
    .sel_for_branch_o     (sel_for_branch_o),
    .dbg_state_o          (dbg_state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one rising edge and settle registered outputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    branch_taken_i       = 1'b0;
    branch_target_i      = 32'h0;
    fence_i_i            = 1'b0;
    stall_pc_i           = 1'b0;
    if_stall_i           = 1'b0;
    i_cache_valid_i      = 1'b0;
    i_cache_inst_i       = 32'h0;
    i_cache_flush_done_i = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    tests++; if (pc_o !== 32'h100) begin fails++; $display("FAIL reset_pc_o got %h exp %h", pc_o, 32'h100); end
    tests++; if (inst_o !== 32'h13) begin fails++; $display("FAIL reset_inst_o got %h exp %h", inst_o, 32'h13); end
    tests++; if (inst_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", inst_valid_o); end
    tests++; if ({i_cache_request_o, i_cache_req_kill_o, i_cache_flush_o, sel_for_branch_o} !== 4'b0000) begin
      fails++; $display("FAIL reset_ctrl got %b exp 0000", {i_cache_request_o, i_cache_req_kill_o, i_cache_flush_o, sel_for_branch_o}); end
    tests++; if (i_cache_addr_o !== 32'h100) begin fails++; $display("FAIL reset_addr got %h exp %h", i_cache_addr_o, 32'h100); end
    tick();
    tests++; if (i_cache_request_o !== 1'b1) begin fails++; $display("FAIL first_request got %b exp 1", i_cache_request_o); end
    tests++; if (i_cache_addr_o !== 32'h100) begin fails++; $display("FAIL first_addr got %h exp %h", i_cache_addr_o, 32'h100); end
  endtask

  task automatic test_back_to_back();
    i_cache_valid_i = 1'b1;
    i_cache_inst_i  = 32'h0000_4501;
    #1;
    tests++; if (i_cache_req_kill_o !== 1'b0) begin fails++; $display("FAIL b2b_kill got %b exp 0", i_cache_req_kill_o); end
    tick();
    tests++; if (inst_o !== 32'h4501) begin fails++; $display("FAIL b2b_inst0 got %h exp %h", inst_o, 32'h4501); end
    tests++; if (pc_o !== 32'h100 || inst_valid_o !== 1'b1) begin fails++; $display("FAIL b2b_pc0 got %h/%b exp 100/1", pc_o, inst_valid_o); end
    tests++; if (i_cache_addr_o !== 32'h102 || i_cache_request_o !== 1'b1) begin fails++; $display("FAIL b2b_addr1 got %h/%b exp 102/1", i_cache_addr_o, i_cache_request_o); end
    i_cache_inst_i = 32'h0000_0093;
    tick();
    tests++; if (inst_o !== 32'h93) begin fails++; $display("FAIL b2b_inst1 got %h exp %h", inst_o, 32'h93); end
    tests++; if (pc_o !== 32'h102 || inst_valid_o !== 1'b1) begin fails++; $display("FAIL b2b_pc1 got %h/%b exp 102/1", pc_o, inst_valid_o); end
    tests++; if (i_cache_addr_o !== 32'h106) begin fails++; $display("FAIL b2b_addr2 got %h exp %h", i_cache_addr_o, 32'h106); end
    i_cache_valid_i = 1'b0;
    tick();
    tests++; if (inst_valid_o !== 1'b0) begin fails++; $display("FAIL b2b_valid_clear got %b exp 0", inst_valid_o); end
    tests++; if (i_cache_request_o !== 1'b1 || i_cache_addr_o !== 32'h106) begin fails++; $display("FAIL b2b_pending got %b/%h exp 1/106", i_cache_request_o, i_cache_addr_o); end
  endtask

  task automatic test_hold();
    // 32-bit word captured while the realigner asserts its stall.
    i_cache_valid_i = 1'b1;
    i_cache_inst_i  = 32'h0000_0013;
    stall_pc_i      = 1'b1;
    tick();
    i_cache_valid_i = 1'b0;
    tests++; if (pc_o !== 32'h106 || inst_valid_o !== 1'b1) begin fails++; $display("FAIL hold_capture got %h/%b exp 106/1", pc_o, inst_valid_o); end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (pc_o !== 32'h106 || inst_o !== 32'h13 || inst_valid_o !== 1'b1) begin
        fails++; $display("FAIL hold_frozen[%0d] got %h/%h/%b exp 106/13/1", i, pc_o, inst_o, inst_valid_o); end
      tests++; if (i_cache_request_o !== 1'b0 || i_cache_addr_o !== 32'h10A) begin
        fails++; $display("FAIL hold_noreq[%0d] got %b/%h exp 0/10a", i, i_cache_request_o, i_cache_addr_o); end
    end
    stall_pc_i = 1'b0;
    tick();
    tests++; if (i_cache_request_o !== 1'b1 || i_cache_addr_o !== 32'h10A) begin fails++; $display("FAIL hold_resume got %b/%h exp 1/10a", i_cache_request_o, i_cache_addr_o); end
    tests++; if (inst_valid_o !== 1'b0) begin fails++; $display("FAIL hold_release_valid got %b exp 0", inst_valid_o); end
  endtask

  task automatic test_branch_kill();
    branch_taken_i  = 1'b1;
    branch_target_i = 32'h0000_2001;
    i_cache_valid_i = 1'b1;
    i_cache_inst_i  = 32'h0000_0093;
    #1;
    tests++; if (i_cache_req_kill_o !== 1'b1 || i_cache_request_o !== 1'b0) begin fails++; $display("FAIL br_kill got %b/%b exp 1/0", i_cache_req_kill_o, i_cache_request_o); end
    tick();
    clear_inputs();
    #1;
    tests++; if (sel_for_branch_o !== 1'b1) begin fails++; $display("FAIL br_sel got %b exp 1", sel_for_branch_o); end
    tests++; if (inst_valid_o !== 1'b0 || inst_o !== 32'h13 || pc_o !== 32'h106) begin
      fails++; $display("FAIL br_dropped got %b/%h/%h exp 0/13/106", inst_valid_o, inst_o, pc_o); end
    tests++; if (i_cache_addr_o !== 32'h2000 || i_cache_request_o !== 1'b0 || i_cache_req_kill_o !== 1'b0) begin
      fails++; $display("FAIL br_idle got %h/%b/%b exp 2000/0/0", i_cache_addr_o, i_cache_request_o, i_cache_req_kill_o); end
    tick();
    tests++; if (sel_for_branch_o !== 1'b0) begin fails++; $display("FAIL br_sel_pulse got %b exp 0", sel_for_branch_o); end
    tests++; if (i_cache_request_o !== 1'b1 || i_cache_addr_o !== 32'h2000) begin fails++; $display("FAIL br_newreq got %b/%h exp 1/2000", i_cache_request_o, i_cache_addr_o); end
  endtask

  task automatic test_fence(input logic [31:0] target, input logic redirect_mid, input logic [31:0] final_addr);
    branch_taken_i  = 1'b1;
    fence_i_i       = 1'b1;
    branch_target_i = target;
    tick();
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      if (redirect_mid && i == 1) begin
        branch_taken_i  = 1'b1;
        branch_target_i = final_addr | 32'h1;
        #1;
        tests++; if (i_cache_req_kill_o !== 1'b0) begin fails++; $display("FAIL fence_mid_kill got %b exp 0", i_cache_req_kill_o); end
      end
      #1;
      tests++; if (i_cache_flush_o !== 1'b1 || i_cache_request_o !== 1'b0) begin
        fails++; $display("FAIL fence_flushing[%0d] got %b/%b exp 1/0", i, i_cache_flush_o, i_cache_request_o); end
      tick();
      clear_inputs();
    end
    i_cache_flush_done_i = 1'b1;
    #1;
    tests++; if (i_cache_flush_o !== 1'b1) begin fails++; $display("FAIL fence_last got %b exp 1", i_cache_flush_o); end
    tick();
    i_cache_flush_done_i = 1'b0;
    tests++; if (i_cache_flush_o !== 1'b0 || i_cache_request_o !== 1'b0) begin fails++; $display("FAIL fence_done got %b/%b exp 0/0", i_cache_flush_o, i_cache_request_o); end
    tick();
    tests++; if (i_cache_request_o !== 1'b1 || i_cache_addr_o !== final_addr) begin
      fails++; $display("FAIL fence_req got %b/%h exp 1/%h", i_cache_request_o, i_cache_addr_o, final_addr); end
  endtask

  task automatic test_wrap();
    branch_taken_i  = 1'b1;
    branch_target_i = 32'hFFFF_FFFF;
    tick();
    clear_inputs();
    tick();
    tests++; if (i_cache_request_o !== 1'b1 || i_cache_addr_o !== 32'hFFFF_FFFE) begin
      fails++; $display("FAIL wrap_req got %b/%h exp 1/fffffffe", i_cache_request_o, i_cache_addr_o); end
    i_cache_valid_i = 1'b1;
    i_cache_inst_i  = 32'h0000_0001;
    tick();
    i_cache_valid_i = 1'b0;
    tests++; if (i_cache_addr_o !== 32'h0) begin fails++; $display("FAIL wrap_addr got %h exp 00000000", i_cache_addr_o); end
    tests++; if (pc_o !== 32'hFFFF_FFFE || inst_valid_o !== 1'b1) begin fails++; $display("FAIL wrap_pc got %h/%b exp fffffffe/1", pc_o, inst_valid_o); end
  endtask

  task automatic test_reset_mid();
    // Response arriving together with reset must be discarded.
    i_cache_valid_i = 1'b1;
    i_cache_inst_i  = 32'h1234_5677;
    reset           = 1'b1;
    tick();
    reset = 1'b0;
    clear_inputs();
    #1;
    tests++; if (inst_valid_o !== 1'b0 || inst_o !== 32'h13 || pc_o !== 32'h100) begin
      fails++; $display("FAIL rst_mid got %b/%h/%h exp 0/13/100", inst_valid_o, inst_o, pc_o); end
    tests++; if (i_cache_request_o !== 1'b0 || i_cache_addr_o !== 32'h100) begin
      fails++; $display("FAIL rst_mid_req got %b/%h exp 0/100", i_cache_request_o, i_cache_addr_o); end
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    test_reset();
    test_back_to_back();
    test_hold();
    test_branch_kill();
    test_fence(32'h0000_0300, 1'b0, 32'h0000_0300);
    test_fence(32'h0000_0500, 1'b1, 32'h0000_0340);
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_pc_gen.md
Name: fetch_pc_gen

Overview:
Instruction-fetch front end that sits directly upstream of the compressed misalignment realigner (c_misalign). It owns the architectural fetch PC and issues single-outstanding I-cache requests. It registers the returned 32-bit fetch word with its PC and forwards the word, PC and valid flag to c_misalign. It also handles branch/jump redirects, realigner stalls, downstream stalls and fence.i cache flushes.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset (bit 0 must be 0).
XLEN, 32, PC/address width.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
branch_taken_i  in  1  redirect request from execute, single-cycle pulse.
branch_target_i  in  XLEN  redirect target; bit 0 is ignored and forced to 0.
fence_i_i  in  1  fence.i; valid only together with branch_taken_i.
stall_pc_i  in  1  hold from c_misalign.
if_stall_i  in  1  downstream decode stall.
i_cache_valid_i  in  1  fetch response valid.
i_cache_inst_i  in  32  fetch word: 32 bits starting at the requested halfword address.
i_cache_flush_done_i  in  1  flush-complete pulse.
i_cache_request_o  out  1  fetch request; held high until the response.
i_cache_req_kill_o  out  1  abort the outstanding request.
i_cache_flush_o  out  1  invalidate the I-cache.
i_cache_addr_o  out  XLEN  request address; equals pc_q.
pc_o  out  XLEN  PC of inst_o; drives c_misalign pc_in.
inst_o  out  32  registered fetch word; drives c_misalign inst_in.
inst_valid_o  out  1  inst_o/pc_o valid; drives c_misalign i_cache_valid.
sel_for_branch_o  out  1  registered redirect flag; drives c_misalign sel_for_branch.

Behaviour:
- Reset values:
  - pc_q = RESET_PC; state = IDLE.
  - pc_o = RESET_PC; inst_o = 32'h0000_0013 (NOP).
  - inst_valid_o, sel_for_branch_o, i_cache_request_o, i_cache_req_kill_o, i_cache_flush_o = 0.
- Reset mid-operation: reset wins over every other input. Any outstanding response is discarded.
- Outstanding requests: at most 1.
- i_cache_addr_o = pc_q at all times.
- FSM states:
  - IDLE: request low. If hold is false, go to WAIT with the request asserted the next cycle. hold = stall_pc_i | if_stall_i.
  - WAIT: request high.
    - On i_cache_valid_i with no redirect: capture inst_o <= i_cache_inst_i, pc_o <= pc_q, inst_valid_o <= 1.
    - Same cycle, advance pc_q by 4 if i_cache_inst_i[1:0]==2'b11, else by 2 (compressed). Arithmetic is modulo 2^XLEN; wrap from 32'hFFFF_FFFE to 0 is legal.
    - Next state is WAIT if hold is false, else IDLE.
  - FLUSH: i_cache_flush_o high, request low. On i_cache_flush_done_i, go to IDLE.
- Hold: while hold=1, pc_q, inst_o, pc_o and inst_valid_o are frozen. No new request is issued; an in-flight request still completes and is captured.
- Output valid: inst_valid_o clears one cycle after a capture if there is no new capture and hold is false (a consumed word is not replayed).
- Redirect (branch_taken_i=1, any state):
  - pc_q <= {branch_target_i[XLEN-1:1],1'b0}.
  - inst_valid_o <= 0; sel_for_branch_o <= 1 for exactly one cycle.
  - If in WAIT, i_cache_req_kill_o=1 combinationally in that cycle and i_cache_request_o drops. A same-cycle i_cache_valid_i is dropped. The cache guarantees no response after the kill.
  - Next state is FLUSH if fence_i_i, else IDLE.
  - A redirect overrides hold.
- Redirect while in FLUSH: pc_q is updated; the state stays FLUSH until done.
- Priority: reset > redirect > i_cache_valid_i > hold.
- Latency: redirect to new request is 2 cycles (redirect, IDLE, request). Response to inst_valid_o is 1 cycle.

Test Plan:
- Reset with RESET_PC=32'h100 -> pc_o=32'h100, inst_o=32'h13, inst_valid_o=0, all cache controls 0. The request rises in the 2nd cycle after reset deasserts, with addr=32'h100.
- Back-to-back fetches of words 32'h0000_4501 (compressed) then 32'h0000_0093 -> addresses 32'h100, 32'h102, 32'h106. pc_o follows 32'h100, 32'h102 with inst_valid_o=1 each.
- stall_pc_i high for 3 cycles after a capture -> pc_o, inst_o and inst_valid_o are frozen and the request stays low. Fetching resumes at the held pc_q on release.
- Branch to 32'h0000_2001 while in WAIT with a same-cycle i_cache_valid_i -> kill=1 for 1 cycle, the response is dropped, sel_for_branch_o pulses once, and the next request has addr=32'h2000.
- fence.i with target 32'h300 -> i_cache_flush_o high until done (delay 5 cycles), no request during the flush, then a request at 32'h300.
- pc_q=32'hFFFF_FFFE fetching a compressed word -> the next request address is 32'h0000_0000.
